alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Issue-and-capture controller on the driving side of the ALU function-unit enable interface. It accepts one operation request through a valid/ready handshake and registers the operands onto the shared unit operand bus. It asserts exactly one function-unit enable, selected by opcode, for a programmable settle window. It then samples the OR-combined unit result bus into a result register and presents that result, with flags, through a second valid/ready handshake.

Parameters:
WIDTH, 4, operand/result width in bits.
NUM_OPS, 8, number of function units; en_vec width; legal opcodes are 0..NUM_OPS-1.
SETTLE_CYCLES, 1, cycles (>=1) the enable is held before the result is sampled.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_op  input  3  opcode; selects en_vec bit.
req_a  input  WIDTH  operand A.
req_b  input  WIDTH  operand B.
unit_a  output  WIDTH  registered operand A to all function units.
unit_b  output  WIDTH  registered operand B to all function units.
en_vec  output  NUM_OPS  one-hot function-unit enables.
unit_y  input  WIDTH  OR of all function-unit outputs (disabled units drive 0).
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_y  output  WIDTH  captured result.
res_zero  output  1  res_y == 0.
res_err  output  1  opcode was illegal.
ops_done  output  8  count of completed result handshakes, wraps 255->0.

Behaviour:
- Asynchronous reset (rst_n=0) forces state IDLE and clears every output register: unit_a, unit_b, en_vec, res_y, res_zero, res_err, res_valid and ops_done all 0. req_ready is 1 after reset because it is decoded from IDLE. Reset mid-operation abandons the operation with no result and no counter increment.
- FSM states: IDLE, DRIVE, HOLD.
- IDLE: req_ready=1, en_vec=0. On a clock edge with req_valid=1, the sequencer:
  - latches req_a into unit_a and req_b into unit_b;
  - latches req_op and loads settle counter = SETTLE_CYCLES-1;
  - moves to DRIVE.
- IDLE with req_valid=0: unit_a and unit_b hold their previous values.
- DRIVE: req_ready=0. en_vec = one-hot(latched op) if op < NUM_OPS, else all zero. The counter decrements each cycle.
- When the counter reaches 0, the next edge:
  - captures res_y = unit_y;
  - sets res_zero = (unit_y == 0);
  - sets res_err = (op >= NUM_OPS), with res_y forced to 0 when res_err=1;
  - sets res_valid=1, clears en_vec and moves to HOLD.
- en_vec is registered. Never more than one bit is set, and it is zero outside DRIVE.
- HOLD: req_ready=0. res_valid=1, and res_y, res_zero and res_err are held stable until a handshake occurs.
- HOLD, on an edge with res_ready=1: res_valid clears, ops_done increments and the FSM returns to IDLE. res_y and the flags retain their values after the handshake.
- Latency: request accepted at edge k. en_vec is high between edges k and k+SETTLE_CYCLES. res_valid rises at edge k+SETTLE_CYCLES. The earliest next acceptance is at the edge after the result handshake, so there is no overlap and no back-to-back issue.
- Requests presented while not in IDLE are ignored because req_ready=0. The requester must hold req_valid and its payload until the handshake.
- res_ready asserted outside HOLD has no effect.
- unit_y is sampled only on the final DRIVE edge and is ignored at all other times.

Test Plan:
- Reset: drive rst_n=0 mid-DRIVE with en_vec=8'b0000_0010 -> en_vec, res_valid, res_y and ops_done are 0 immediately (asynchronous); req_ready=1 after rst_n=1; no result is produced.
- Basic OR issue (SETTLE_CYCLES=1): req_op=1, A=4'b1010, B=4'b0101; bench unit 1 returns A|B gated by en_vec[1] -> en_vec=8'b0000_0010 for exactly 1 cycle; res_valid at accept+1; res_y=4'hF, res_zero=0, res_err=0.
- Zero result: req_op=0 (bench AND unit), A=4'h3, B=4'hC -> res_y=4'h0, res_zero=1.
- Illegal opcode with NUM_OPS=6: req_op=7 -> en_vec stays 0 throughout; res_err=1, res_y=0, res_zero=1.
- Backpressure plus settle: SETTLE_CYCLES=3, res_ready held 0 for 5 cycles -> en_vec high for 3 cycles; res_valid and res_y stable for those 5 cycles; req_ready=0 and new req_valid is ignored; ops_done increments once on release.
- Counter wrap: complete 256 operations -> ops_done reads 255 and then 0; each acceptance requires a fresh handshake with no overlapping issue.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue-and-capture controller for the ALU function-unit enable interface.
// It issues one request, holds one unit enable for a settle window, then captures and presents the result.
module alu_op_sequencer #(
    parameter int WIDTH         = 4,
    parameter int NUM_OPS       = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   unit_a,
    output logic [WIDTH-1:0]   unit_b,
    output logic [NUM_OPS-1:0] en_vec,
    input  logic [WIDTH-1:0]   unit_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_y,
    output logic               res_zero,
    output logic               res_err,
    output logic [7:0]         ops_done
);

    // state | meaning
    // IDLE  | ready for a request, no enable asserted
    // DRIVE | one unit enabled, settle counter running down to 0
    // HOLD  | result presented, waiting for res_ready
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt;
    logic               accept, finish, done_hs;
    logic               req_legal, op_legal_q;
    logic [NUM_OPS-1:0] req_onehot;
    logic [WIDTH-1:0]   y_capt;

    assign req_ready  = (state == IDLE);
    assign req_legal  = (32'(req_op) < NUM_OPS);
    assign op_legal_q = (32'(op_q) < NUM_OPS);
    assign req_onehot = req_legal ? (NUM_OPS'(1) << req_op) : '0;
    // An illegal opcode never enabled a unit, but the result is still forced to zero.
    assign y_capt     = op_legal_q ? unit_y : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        done_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    done_hs   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_a    <= '0;
            unit_b    <= '0;
            op_q      <= '0;
            cnt       <= '0;
            en_vec    <= '0;
            res_y     <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                unit_a <= req_a;
                unit_b <= req_b;
                op_q   <= req_op;
                cnt    <= CW'(SETTLE_CYCLES - 1);
                en_vec <= req_onehot;
            end else if (state == DRIVE && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                res_y     <= y_capt;
                res_zero  <= (y_capt == '0);
                res_err   <= ~op_legal_q;
                res_valid <= 1'b1;
                en_vec    <= '0;
            end
            if (done_hs) begin
                res_valid <= 1'b0;
                ops_done  <= ops_done + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 has 6 units and settle 1, instance 1 has 8 units and settle 3.
// Bench-side function units drive unit_y; expected results are hand-computed in the vector table.
module tb_alu_op_sequencer;

    typedef struct {
        int         s;
        logic [2:0] op;
        logic [3:0] a, b, y;
        logic       z, e;
        logic [7:0] en;
        int         stall;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req_op = '0;
    logic [3:0] req_a = '0, req_b = '0;
    logic [1:0] req_valid = '0, res_ready = '0;
    logic [1:0] req_ready, res_valid, res_zero, res_err;
    logic [3:0] ua[2], ub[2], ry[2], uy[2];
    logic [7:0] od[2], en8[2];
    logic [5:0] en0;
    logic [7:0] en1;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_cnt[2] = '{8'd0, 8'd0};
    vec_t tv[12];

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(4), .NUM_OPS(6), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .unit_a(ua[0]), .unit_b(ub[0]),
        .en_vec(en0), .unit_y(uy[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_y(ry[0]), .res_zero(res_zero[0]), .res_err(res_err[0]), .ops_done(od[0]));

    alu_op_sequencer #(.WIDTH(4), .NUM_OPS(8), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .unit_a(ua[1]), .unit_b(ub[1]),
        .en_vec(en1), .unit_y(uy[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_y(ry[1]), .res_zero(res_zero[1]), .res_err(res_err[1]), .ops_done(od[1]));

    assign en8[0] = {2'b00, en0};
    assign en8[1] = en1;

    function automatic logic [3:0] fu(int k, logic [3:0] a, logic [3:0] b);
        case (k)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            3:       return a + b;
            4:       return a - b;
            5:       return ~a;
            6:       return a;
            default: return b;
        endcase
    endfunction

    always_comb begin
        uy[0] = '0;
        uy[1] = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 6 && en0[k]) uy[0] = uy[0] | fu(k, ua[0], ub[0]);
            if (en1[k])          uy[1] = uy[1] | fu(k, ua[1], ub[1]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request on instance s and walk it through DRIVE, HOLD and the result handshake.
    task automatic do_op(input int s, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] y, input logic z, input logic e,
                         input logic [7:0] en, input int stall);
        int settle;
        settle = (s == 0) ? 1 : 3;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        chk("unit_a", 32'(ua[s]), 32'(a));
        chk("unit_b", 32'(ub[s]), 32'(b));
        for (int i = 0; i < settle; i++) begin
            chk("en_vec_drive", 32'(en8[s]), 32'(en));
            chk("res_valid_drive", 32'(res_valid[s]), 32'd0);
            chk("req_ready_drive", 32'(req_ready[s]), 32'd0);
            @(negedge clk);
        end
        chk("en_vec_after", 32'(en8[s]), 32'd0);
        chk("res_valid", 32'(res_valid[s]), 32'd1);
        chk("res_y", 32'(ry[s]), 32'(y));
        chk("res_zero", 32'(res_zero[s]), 32'(z));
        chk("res_err", 32'(res_err[s]), 32'(e));
        for (int i = 0; i < stall; i++) begin
            req_valid[s] = 1'b1; req_op = 3'd0; req_a = ~a; req_b = ~b;
            @(negedge clk);
            chk("stall_valid", 32'(res_valid[s]), 32'd1);
            chk("stall_y", 32'(ry[s]), 32'(y));
            chk("stall_ready", 32'(req_ready[s]), 32'd0);
            chk("stall_en", 32'(en8[s]), 32'd0);
            chk("stall_count", 32'(od[s]), 32'(exp_cnt[s]));
        end
        req_valid[s] = 1'b0;
        res_ready[s] = 1'b1;
        @(negedge clk);
        res_ready[s] = 1'b0;
        exp_cnt[s] = exp_cnt[s] + 8'd1;
        chk("res_valid_cleared", 32'(res_valid[s]), 32'd0);
        chk("req_ready_back", 32'(req_ready[s]), 32'd1);
        chk("ops_done", 32'(od[s]), 32'(exp_cnt[s]));
        chk("res_y_kept", 32'(ry[s]), 32'(y));
        chk("res_err_kept", 32'(res_err[s]), 32'(e));
        chk("unit_a_kept", 32'(ua[s]), 32'(a));
    endtask

    initial begin
        //        s  op    a      b      y      z     e     en            stall
        tv[0]  = '{0, 3'd1, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 8'b0000_0010, 0};
        tv[1]  = '{0, 3'd0, 4'h3, 4'hC, 4'h0, 1'b1, 1'b0, 8'b0000_0001, 1};
        tv[2]  = '{0, 3'd2, 4'h6, 4'h3, 4'h5, 1'b0, 1'b0, 8'b0000_0100, 0};
        tv[3]  = '{0, 3'd3, 4'h9, 4'h8, 4'h1, 1'b0, 1'b0, 8'b0000_1000, 0};
        tv[4]  = '{0, 3'd5, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 8'b0010_0000, 0};
        tv[5]  = '{0, 3'd6, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 8'b0000_0000, 2};
        tv[6]  = '{0, 3'd7, 4'h5, 4'h7, 4'h0, 1'b1, 1'b1, 8'b0000_0000, 0};
        tv[7]  = '{0, 3'd4, 4'h2, 4'h3, 4'hF, 1'b0, 1'b0, 8'b0001_0000, 0};
        tv[8]  = '{1, 3'd1, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 8'b0000_0010, 5};
        tv[9]  = '{1, 3'd7, 4'h5, 4'hA, 4'hA, 1'b0, 1'b0, 8'b1000_0000, 0};
        tv[10] = '{1, 3'd6, 4'h7, 4'h0, 4'h7, 1'b0, 1'b0, 8'b0100_0000, 1};
        tv[11] = '{1, 3'd4, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 8'b0001_0000, 0};

        #12;
        chk("reset_valid0", 32'(res_valid[0]), 32'd0);
        chk("reset_en0", 32'(en8[0]), 32'd0);
        chk("reset_count1", 32'(od[1]), 32'd0);
        chk("reset_ready1", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            do_op(tv[i].s, tv[i].op, tv[i].a, tv[i].b, tv[i].y, tv[i].z, tv[i].e, tv[i].en, tv[i].stall);

        // Asynchronous reset in the middle of DRIVE abandons the operation.
        @(negedge clk);
        req_valid[1] = 1'b1; req_op = 3'd1; req_a = 4'h1; req_b = 4'h2;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("mid_drive_en", 32'(en8[1]), 32'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", 32'(en8[1]), 32'd0);
        chk("async_valid", 32'(res_valid[1]), 32'd0);
        chk("async_res_y", 32'(ry[1]), 32'd0);
        chk("async_count", 32'(od[1]), 32'd0);
        chk("async_count0", 32'(od[0]), 32'd0);
        chk("async_unit_a", 32'(ua[1]), 32'd0);
        exp_cnt[0] = 8'd0;
        exp_cnt[1] = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset_ready", 32'(req_ready[1]), 32'd1);
        repeat (5) @(negedge clk);
        chk("no_result_valid", 32'(res_valid[1]), 32'd0);
        chk("no_result_en", 32'(en8[1]), 32'd0);
        chk("no_result_count", 32'(od[1]), 32'd0);

        // OR with B=0 returns A, so each result equals its operand.
        for (int i = 0; i < 255; i++) begin
            logic [3:0] a;
            a = 4'(i);
            do_op(0, 3'd1, a, 4'h0, a, (a == 4'h0), 1'b0, 8'b0000_0010, 0);
        end
        chk("wrap_255", 32'(od[0]), 32'd255);
        do_op(0, 3'd1, 4'h8, 4'h0, 4'h8, 1'b0, 1'b0, 8'b0000_0010, 0);
        chk("wrap_0", 32'(od[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
